// File: rtl/wb_cmd_master_pkg.sv
// Shared types for wb_cmd_master: the controller state encoding and the
// 2-bit response status returned with every completed command.
package wb_cmd_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RETRY = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        STATUS_OK  = 2'd0,
        STATUS_ERR = 2'd1,
        STATUS_RTY = 2'd2,
        STATUS_TMO = 2'd3
    } status_t;

    localparam logic [1:0] RSP_OK  = 2'd0;
    localparam logic [1:0] RSP_ERR = 2'd1;
    localparam logic [1:0] RSP_RTY = 2'd2;
    localparam logic [1:0] RSP_TMO = 2'd3;

endpackage

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone pipelined master: takes one command, runs it on
// the bus with retry and timeout handling, and returns data plus status.
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int G_ADDR_WIDTH = 32,
    parameter int G_TIMEOUT    = 255,
    parameter int G_MAX_RETRY  = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_we_i,
    input  logic [G_ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [3:0]              cmd_sel_i,
    input  logic [31:0]             cmd_dat_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [31:0]             rsp_dat_o,
    output logic [1:0]              rsp_status_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [G_ADDR_WIDTH-1:0] wb_adr_o,
    output logic [3:0]              wb_sel_o,
    output logic [31:0]             wb_dat_o,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    wb_rty_i,
    input  logic                    wb_stall_i,
    input  logic [31:0]             wb_dat_i
);

    localparam int TMO_W = $clog2(G_TIMEOUT + 1);
    localparam int RTY_W = (G_MAX_RETRY > 0) ? $clog2(G_MAX_RETRY + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(G_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(G_MAX_RETRY);

    state_t           state;
    state_t           state_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [RTY_W-1:0] rty_cnt;

    logic             accept;
    logic             retry;
    logic             rsp_load;
    status_t          rsp_status_nxt;
    logic [31:0]      rsp_dat_nxt;
    logic             term_en;
    logic             tmo_hit;

    // Bus controls and response valid decode straight from the state register,
    // so an asynchronous reset drops them without waiting for a clock.
    assign wb_cyc_o    = (state == ST_REQ) || (state == ST_WAIT);
    assign wb_stb_o    = (state == ST_REQ);
    assign rsp_valid_o = (state == ST_RESP);

    always_comb begin
        state_nxt      = state;
        accept         = 1'b0;
        retry          = 1'b0;
        rsp_load       = 1'b0;
        rsp_status_nxt = STATUS_OK;
        rsp_dat_nxt    = '0;
        term_en        = 1'b0;
        // The cycle being closed is the G_TIMEOUT-th one with cyc high.
        tmo_hit        = (tmo_cnt == TMO_LAST);

        case (state)
            ST_IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    accept    = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ, ST_WAIT: begin
                // While stalled the strobe has not been taken, so no reply can belong to it.
                term_en = (state == ST_WAIT) || !wb_stall_i;
                if (term_en && wb_err_i) begin
                    rsp_load       = 1'b1;
                    rsp_status_nxt = STATUS_ERR;
                    state_nxt      = ST_RESP;
                end else if (term_en && wb_rty_i) begin
                    if (rty_cnt < RTY_MAX) begin
                        retry     = 1'b1;
                        state_nxt = ST_RETRY;
                    end else begin
                        rsp_load       = 1'b1;
                        rsp_status_nxt = STATUS_RTY;
                        state_nxt      = ST_RESP;
                    end
                end else if (term_en && wb_ack_i) begin
                    rsp_load       = 1'b1;
                    rsp_status_nxt = STATUS_OK;
                    rsp_dat_nxt    = wb_we_o ? 32'd0 : wb_dat_i;
                    state_nxt      = ST_RESP;
                end else if (tmo_hit) begin
                    rsp_load       = 1'b1;
                    rsp_status_nxt = STATUS_TMO;
                    state_nxt      = ST_RESP;
                end else if ((state == ST_REQ) && !wb_stall_i) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_RETRY: begin
                state_nxt = ST_REQ;
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= ST_IDLE;
            cmd_ready_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            cmd_ready_o <= (state_nxt == ST_IDLE);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmo_cnt      <= '0;
            rty_cnt      <= '0;
            wb_we_o      <= 1'b0;
            wb_adr_o     <= '0;
            wb_sel_o     <= '0;
            wb_dat_o     <= '0;
            rsp_dat_o    <= '0;
            rsp_status_o <= '0;
        end else begin
            if (accept) begin
                wb_we_o  <= cmd_we_i;
                wb_adr_o <= cmd_adr_i;
                wb_sel_o <= cmd_sel_i;
                wb_dat_o <= cmd_we_i ? cmd_dat_i : 32'd0;
                rty_cnt  <= '0;
            end else if (retry) begin
                rty_cnt <= rty_cnt + RTY_W'(1);
            end

            if ((state_nxt == ST_REQ) && (state != ST_REQ)) begin
                tmo_cnt <= '0;
            end else if ((state == ST_REQ) || (state == ST_WAIT)) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            if (rsp_load) begin
                rsp_dat_o    <= rsp_dat_nxt;
                rsp_status_o <= rsp_status_nxt;
            end
        end
    end

endmodule
